aes_round_sequencer: RTL and testbench

AES_ROUND_SEQUENCER -- requirements
Module: aes_round_sequencer

---
 rtl/aes_round_sequencer.sv | 113 +++++++++++
 tb/tb_aes_round_sequencer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_sequencer.sv
// Control sequencer for an iterative AES-128 datapath: accepts a block, steps it
// through NR rounds (the last one without mix-columns), then holds ciphertext until it is consumed.
module aes_round_sequencer #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       load_en,
  output logic       rnd_en,
  output logic       mc_bypass,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [3:0] LAST_ROUND = 4'(NR);
  localparam logic [3:0] PENULT     = 4'(NR - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The counter saturates at the last round rather than wrapping.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = ROUND;
          cnt_d   = 4'd1;
        end
      end
      ROUND: begin
        if (cnt_q >= PENULT) begin
          state_d = FINAL;
          cnt_d   = LAST_ROUND;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      FINAL: state_d = DONE;
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    rnd_en    = 1'b0;
    mc_bypass = 1'b0;
    case (state_q)
      IDLE:  in_ready = 1'b1;
      ROUND: rnd_en = 1'b1;
      FINAL: begin
        rnd_en    = 1'b1;
        mc_bypass = 1'b1;
      end
      DONE:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
    load_en   = in_valid & in_ready;
    busy      = ~in_ready;
    round_idx = cnt_q;
  end

  // Round constants are successive GF(2^8) doublings of 01.
  always_comb begin
    case (cnt_q)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1B;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench for aes_round_sequencer: a block-level model tracks cycles
// since accept and predicts every output each cycle, plus scenario-specific timing checks.
module tb_aes_round_sequencer;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       load_en;
  logic       rnd_en;
  logic       mc_bypass;
  logic [3:0] round_idx;
  logic [7:0] rcon;
  logic       busy;

  int checks = 0;
  int errors = 0;

  // Model: whether a block is in flight, and how many cycles since it was accepted.
  bit m_busy = 1'b0;
  int m_t    = 0;

  aes_round_sequencer #(.NR(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .load_en   (load_en),
    .rnd_en    (rnd_en),
    .mc_bypass (mc_bypass),
    .round_idx (round_idx),
    .rcon      (rcon),
    .busy      (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  // Packed view: {in_ready, load_en, out_valid, rnd_en, mc_bypass, busy, round_idx, rcon}
  function automatic logic [17:0] observed();
    return {in_ready, load_en, out_valid, rnd_en, mc_bypass, busy, round_idx, rcon};
  endfunction

  function automatic logic [17:0] expected(input logic iv);
    int         r;
    logic [7:0] rc;
    r  = !m_busy ? 0 : (m_t > 10 ? 10 : m_t);
    rc = 8'h00;
    if (r >= 1) begin
      rc = 8'h01;
      for (int k = 1; k < r; k++) rc = xtime(rc);
    end
    return {!m_busy, iv & !m_busy, m_busy && m_t >= 11, m_busy && m_t <= 10,
            m_busy && m_t == 10, m_busy, 4'(r), rc};
  endfunction

  task automatic drive(input logic iv, input logic ordy, input logic rs);
    in_valid  = iv;
    out_ready = ordy;
    rst       = rs;
    #1;
  endtask

  task automatic advance(input logic iv, input logic ordy, input logic rs);
    if (rs) begin
      m_busy = 1'b0;
      m_t    = 0;
    end else if (!m_busy) begin
      if (iv) begin
        m_busy = 1'b1;
        m_t    = 1;
      end
    end else if (m_t >= 11) begin
      if (ordy) m_busy = 1'b0;
    end else begin
      m_t++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1);
    advance(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (observed() !== expected(1'b0)) begin
      errors++;
      $display("[TB] FAIL reset_hold observed %h expected %h", observed(), expected(1'b0));
    end
    advance(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (observed() !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL reset_state observed %h expected %h", observed(),
               {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00});
    end
    advance(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_single_block();
    int first_ov = -1;
    int rnd_cnt  = 0;
    int mc_cyc   = -1;
    logic ir12   = 1'b0;
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c <= 13; c++) begin
      drive(c == 0, 1'b1, 1'b0);
      checks++;
      if (observed() !== expected(c == 0)) begin
        errors++;
        $display("[TB] FAIL single cycle %0d observed %h expected %h", c, observed(), expected(c == 0));
      end
      if (out_valid && first_ov < 0) first_ov = c;
      if (rnd_en) rnd_cnt++;
      if (mc_bypass) mc_cyc = c;
      if (c == 12) ir12 = in_ready;
      advance(c == 0, 1'b1, 1'b0);
    end
    checks++;
    if (first_ov !== 11 || rnd_cnt !== 10 || mc_cyc !== 10 || ir12 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_latency observed ov=%0d rnd=%0d mc=%0d ir12=%b expected ov=11 rnd=10 mc=10 ir12=1",
               first_ov, rnd_cnt, mc_cyc, ir12);
    end
  endtask

  task automatic test_backpressure();
    logic ok = 1'b1;
    logic ordy;
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c <= 18; c++) begin
      ordy = (c < 11 || c > 16);
      drive(c == 0, ordy, 1'b0);
      checks++;
      if (observed() !== expected(c == 0)) begin
        errors++;
        $display("[TB] FAIL backpressure cycle %0d observed %h expected %h", c, observed(), expected(c == 0));
      end
      if (c >= 11 && c <= 17 && !(out_valid && round_idx == 4'd10 && !in_ready)) ok = 1'b0;
      if (c == 18 && !in_ready) ok = 1'b0;
      advance(c == 0, ordy, 1'b0);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++;
      $display("[TB] FAIL backpressure_hold observed %b expected 1", ok);
    end
  endtask

  task automatic test_busy_ignore();
    int loads = 0;
    logic iv;
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c <= 12; c++) begin
      iv = (c == 0 || c == 3 || c == 11);
      drive(iv, 1'b1, 1'b0);
      checks++;
      if (observed() !== expected(iv)) begin
        errors++;
        $display("[TB] FAIL busy_ignore cycle %0d observed %h expected %h", c, observed(), expected(iv));
      end
      if (load_en) loads++;
      advance(iv, 1'b1, 1'b0);
    end
    checks++;
    if (loads !== 1) begin
      errors++;
      $display("[TB] FAIL busy_ignore_loads observed %0d expected 1", loads);
    end
  endtask

  task automatic test_midrun_reset();
    int first_ov = -1;
    logic idx6 = 1'b0;
    logic iv, rs;
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c <= 19; c++) begin
      iv = (c == 0 || c == 7);
      rs = (c == 5);
      drive(iv, 1'b1, rs);
      checks++;
      if (observed() !== expected(iv)) begin
        errors++;
        $display("[TB] FAIL midrun_reset cycle %0d observed %h expected %h", c, observed(), expected(iv));
      end
      if (c == 6) idx6 = in_ready && round_idx == 4'd0;
      if (out_valid && first_ov < 0) first_ov = c;
      advance(iv, 1'b1, rs);
    end
    checks++;
    if (first_ov !== 18 || idx6 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midrun_reset_timing observed ov=%0d idle6=%b expected ov=18 idle6=1", first_ov, idx6);
    end
  endtask

  task automatic test_back_to_back();
    int loads[$];
    int ovs[$];
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c <= 35; c++) begin
      drive(1'b1, 1'b1, 1'b0);
      checks++;
      if (observed() !== expected(1'b1)) begin
        errors++;
        $display("[TB] FAIL back_to_back cycle %0d observed %h expected %h", c, observed(), expected(1'b1));
      end
      if (load_en) loads.push_back(c);
      if (out_valid) ovs.push_back(c);
      advance(1'b1, 1'b1, 1'b0);
    end
    checks++;
    if (loads.size() != 3 || ovs.size() != 3 ||
        loads[0] != 0 || loads[1] != 12 || loads[2] != 24 ||
        ovs[0] != 11 || ovs[1] != 23 || ovs[2] != 35) begin
      errors++;
      $display("[TB] FAIL back_to_back_timing observed loads=%p ovs=%p expected loads 0,12,24 ovs 11,23,35",
               loads, ovs);
    end
  endtask

  task automatic test_random();
    logic iv, ordy, rs;
    drive(1'b0, 1'b1, 1'b1);
    advance(1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 600; c++) begin
      iv   = ($urandom_range(0, 1) == 1);
      ordy = ($urandom_range(0, 4) < 3);
      rs   = ($urandom_range(0, 59) == 0);
      drive(iv, ordy, rs);
      checks++;
      if (observed() !== expected(iv)) begin
        errors++;
        $display("[TB] FAIL random cycle %0d observed %h expected %h", c, observed(), expected(iv));
      end
      advance(iv, ordy, rs);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_single_block();
    test_backpressure();
    test_busy_ignore();
    test_midrun_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
